axis_grant_gate: RTL and testbench

//  Per-channel, packet-atomic AXI-Stream gate for the Heartbeat app: IF_COUNT independent channels, each

---
 rtl/axis_grant_gate_pkg.sv | 43 ++++
 rtl/axis_gate_skid.sv | 78 +++++++
 rtl/axis_grant_gate.sv | 126 ++++++++++++
 tb/tb_axis_grant_gate.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_grant_gate_pkg.sv
// Shared definitions for the per-channel AXI-Stream grant gate:
// FSM state encodings and the state transition function.
package axis_grant_gate_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_PASS = 2'd1;
  localparam logic [STATE_W-1:0] ST_DROP = 2'd2;

  // Next state for one channel. A packet is only started from IDLE.
  // Once in PASS or DROP, the packet is left only on the handshaked tlast
  // beat, so grant changes mid-packet have no effect.
  function automatic logic [STATE_W-1:0] gate_next_state(
    input logic [STATE_W-1:0] st,
    input logic               grant,
    input logic               valid,
    input logic               last_hs,
    input logic               drop_en
  );
    logic [STATE_W-1:0] nxt;
    nxt = st;
    case (st)
      ST_IDLE: begin
        if (valid) begin
          if (grant) begin
            nxt = ST_PASS;
          end else if (drop_en) begin
            nxt = ST_DROP;
          end
        end
      end
      ST_PASS, ST_DROP: begin
        if (last_hs) begin
          nxt = ST_IDLE;
        end
      end
      default: nxt = ST_IDLE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/axis_gate_skid.sv
// One-channel, two-entry registered skid buffer. The output register and
// in_ready are both flops, so neither out_valid nor in_ready depends
// combinationally on out_ready. A beat accepted on one edge is visible on
// the output after that edge; full throughput when out_ready stays high.
module axis_gate_skid #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  logic [DATA_W-1:0] out_data_p1;
  logic [DATA_W-1:0] tmp_data_p1;
  logic              vld_p1;
  logic              tmp_vld_p1;
  logic              rdy_p0;
  logic              rdy_early;
  logic              load_out;
  logic              load_tmp;
  logic              tmp_to_out;

  // Ready for the next cycle: the output drains, or the spare entry stays
  // free even if this cycle's beat lands in the output register.
  assign rdy_early  = out_ready | (~tmp_vld_p1 & (~vld_p1 | ~in_valid));
  assign load_out   = rdy_p0 & in_valid & (out_ready | ~vld_p1);
  assign load_tmp   = rdy_p0 & in_valid & ~out_ready & vld_p1;
  assign tmp_to_out = ~rdy_p0 & out_ready & tmp_vld_p1;

  // Occupancy and ready flags; reset empties both entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      tmp_vld_p1 <= 1'b0;
      rdy_p0     <= 1'b0;
    end else begin
      rdy_p0 <= rdy_early;
      if (rdy_p0) begin
        if (out_ready | ~vld_p1) begin
          vld_p1 <= in_valid;
        end else begin
          tmp_vld_p1 <= in_valid;
        end
      end else if (out_ready) begin
        vld_p1     <= tmp_vld_p1;
        tmp_vld_p1 <= 1'b0;
      end
    end
  end

  // Output payload register; cleared on reset so the idle bus reads zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_p1 <= '0;
    end else if (load_out) begin
      out_data_p1 <= in_data;
    end else if (tmp_to_out) begin
      out_data_p1 <= tmp_data_p1;
    end
  end

  // Spare entry captures the beat that arrives while the output is stalled.
  always_ff @(posedge clk) begin
    if (load_tmp) begin
      tmp_data_p1 <= in_data;
    end
  end

  assign in_ready  = rdy_p0;
  assign out_data  = out_data_p1;
  assign out_valid = vld_p1;

endmodule

// File: rtl/axis_grant_gate.sv
// Per-channel, packet-atomic AXI-Stream gate. Each channel starts a packet
// only while its grant is held, forwards it whole through a registered
// skid, or discards it when ungranted and DROP_WHEN_IDLE is set.
module axis_grant_gate
  import axis_grant_gate_pkg::*;
#(
  parameter int IF_COUNT        = 1,
  parameter int AXIS_DATA_WIDTH = 64,
  parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
  parameter int AXIS_ID_WIDTH   = 1,
  parameter int AXIS_DEST_WIDTH = 9,
  parameter int AXIS_USER_WIDTH = 97,
  parameter int COUNT_WIDTH     = 32,
  parameter int DROP_WHEN_IDLE  = 0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [IF_COUNT-1:0]                  grant,
  input  logic [IF_COUNT*AXIS_DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [IF_COUNT*AXIS_KEEP_WIDTH-1:0]  s_axis_tkeep,
  input  logic [IF_COUNT-1:0]                  s_axis_tvalid,
  output logic [IF_COUNT-1:0]                  s_axis_tready,
  input  logic [IF_COUNT-1:0]                  s_axis_tlast,
  input  logic [IF_COUNT*AXIS_USER_WIDTH-1:0]  s_axis_tuser,
  input  logic [IF_COUNT*AXIS_ID_WIDTH-1:0]    s_axis_tid,
  input  logic [IF_COUNT*AXIS_DEST_WIDTH-1:0]  s_axis_tdest,
  output logic [IF_COUNT*AXIS_DATA_WIDTH-1:0]  m_axis_tdata,
  output logic [IF_COUNT*AXIS_KEEP_WIDTH-1:0]  m_axis_tkeep,
  output logic [IF_COUNT-1:0]                  m_axis_tvalid,
  input  logic [IF_COUNT-1:0]                  m_axis_tready,
  output logic [IF_COUNT-1:0]                  m_axis_tlast,
  output logic [IF_COUNT*AXIS_USER_WIDTH-1:0]  m_axis_tuser,
  output logic [IF_COUNT*AXIS_ID_WIDTH-1:0]    m_axis_tid,
  output logic [IF_COUNT*AXIS_DEST_WIDTH-1:0]  m_axis_tdest,
  output logic [IF_COUNT-1:0]                  busy,
  output logic [IF_COUNT*COUNT_WIDTH-1:0]      pkt_count,
  output logic [IF_COUNT*COUNT_WIDTH-1:0]      drop_count
);

  localparam int DW    = AXIS_DATA_WIDTH;
  localparam int KW    = AXIS_KEEP_WIDTH;
  localparam int IW    = AXIS_ID_WIDTH;
  localparam int SW    = AXIS_DEST_WIDTH;
  localparam int UW    = AXIS_USER_WIDTH;
  localparam int PAY_W = DW + KW + 1 + UW + IW + SW;

  localparam logic DROP_EN = (DROP_WHEN_IDLE != 0);

  for (genvar i = 0; i < IF_COUNT; i++) begin : g_ch
    logic [STATE_W-1:0]     state_q;
    logic [COUNT_WIDTH-1:0] pkt_q;
    logic [COUNT_WIDTH-1:0] drop_q;
    logic                   in_pass;
    logic                   in_drop;
    logic                   skid_rdy;
    logic                   s_rdy;
    logic                   hs;
    logic                   last_hs;
    logic                   m_vld;
    logic [PAY_W-1:0]       s_pay;
    logic [PAY_W-1:0]       m_pay;

    assign in_pass = (state_q == ST_PASS);
    assign in_drop = (state_q == ST_DROP);

    // s_tready is a function of flops only: the state and the skid's ready.
    assign s_rdy   = (in_pass & skid_rdy) | in_drop;
    assign hs      = s_axis_tvalid[i] & s_rdy;
    assign last_hs = hs & s_axis_tlast[i];

    assign s_pay = {s_axis_tdata[i*DW +: DW], s_axis_tkeep[i*KW +: KW],
                    s_axis_tlast[i], s_axis_tuser[i*UW +: UW],
                    s_axis_tid[i*IW +: IW], s_axis_tdest[i*SW +: SW]};

    // Channel FSM: IDLE -> PASS/DROP on a new packet, back on its last beat.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= ST_IDLE;
      end else begin
        state_q <= gate_next_state(state_q, grant[i], s_axis_tvalid[i],
                                   last_hs, DROP_EN);
      end
    end

    // Packet and drop counters, bumped on the accepted tlast beat; wrap.
    always_ff @(posedge clk) begin
      if (rst) begin
        pkt_q  <= '0;
        drop_q <= '0;
      end else begin
        if (in_pass & last_hs) begin
          pkt_q <= pkt_q + COUNT_WIDTH'(1);
        end
        if (in_drop & last_hs) begin
          drop_q <= drop_q + COUNT_WIDTH'(1);
        end
      end
    end

    // Only PASS feeds the skid; DROP consumes beats without touching it,
    // and the skid drains on its own after the packet ends.
    axis_gate_skid #(
      .DATA_W(PAY_W)
    ) u_skid (
      .clk      (clk),
      .rst      (rst),
      .in_data  (s_pay),
      .in_valid (s_axis_tvalid[i] & in_pass),
      .in_ready (skid_rdy),
      .out_data (m_pay),
      .out_valid(m_vld),
      .out_ready(m_axis_tready[i])
    );

    assign {m_axis_tdata[i*DW +: DW], m_axis_tkeep[i*KW +: KW],
            m_axis_tlast[i], m_axis_tuser[i*UW +: UW],
            m_axis_tid[i*IW +: IW], m_axis_tdest[i*SW +: SW]} = m_pay;

    assign m_axis_tvalid[i]                    = m_vld;
    assign s_axis_tready[i]                    = s_rdy;
    assign busy[i]                             = (state_q != ST_IDLE);
    assign pkt_count[i*COUNT_WIDTH +: COUNT_WIDTH]  = pkt_q;
    assign drop_count[i*COUNT_WIDTH +: COUNT_WIDTH] = drop_q;
  end

endmodule

// File: tb/tb_axis_grant_gate.sv
// Directed bench for axis_grant_gate: a two-channel stalling instance (a_*)
// and a one-channel drop-mode instance with 2-bit counters (b_*).
module tb_axis_grant_gate;

  localparam int DW = 16;
  localparam int KW = 2;
  localparam int IW = 1;
  localparam int SW = 9;
  localparam int UW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: IF_COUNT=2, stall when ungranted, 8-bit counters
  logic [1:0]      a_grant;
  logic [2*DW-1:0] a_s_tdata,  a_m_tdata;
  logic [2*KW-1:0] a_s_tkeep,  a_m_tkeep;
  logic [1:0]      a_s_tvalid, a_s_tready, a_s_tlast;
  logic [1:0]      a_m_tvalid, a_m_tready, a_m_tlast;
  logic [2*UW-1:0] a_s_tuser,  a_m_tuser;
  logic [2*IW-1:0] a_s_tid,    a_m_tid;
  logic [2*SW-1:0] a_s_tdest,  a_m_tdest;
  logic [1:0]      a_busy;
  logic [15:0]     a_pkt, a_drop;

  // Instance B: IF_COUNT=1, drop when ungranted, 2-bit counters
  logic          b_grant;
  logic [DW-1:0] b_s_tdata, b_m_tdata;
  logic [KW-1:0] b_s_tkeep, b_m_tkeep;
  logic          b_s_tvalid, b_s_tready, b_s_tlast;
  logic          b_m_tvalid, b_m_tready, b_m_tlast;
  logic [UW-1:0] b_s_tuser, b_m_tuser;
  logic [IW-1:0] b_s_tid, b_m_tid;
  logic [SW-1:0] b_s_tdest, b_m_tdest;
  logic          b_busy;
  logic [1:0]    b_pkt, b_drop;

  axis_grant_gate #(
    .IF_COUNT(2), .AXIS_DATA_WIDTH(DW), .AXIS_KEEP_WIDTH(KW), .AXIS_ID_WIDTH(IW),
    .AXIS_DEST_WIDTH(SW), .AXIS_USER_WIDTH(UW), .COUNT_WIDTH(8), .DROP_WHEN_IDLE(0)
  ) dut_a (
    .clk(clk), .rst(rst), .grant(a_grant),
    .s_axis_tdata(a_s_tdata), .s_axis_tkeep(a_s_tkeep), .s_axis_tvalid(a_s_tvalid),
    .s_axis_tready(a_s_tready), .s_axis_tlast(a_s_tlast), .s_axis_tuser(a_s_tuser),
    .s_axis_tid(a_s_tid), .s_axis_tdest(a_s_tdest),
    .m_axis_tdata(a_m_tdata), .m_axis_tkeep(a_m_tkeep), .m_axis_tvalid(a_m_tvalid),
    .m_axis_tready(a_m_tready), .m_axis_tlast(a_m_tlast), .m_axis_tuser(a_m_tuser),
    .m_axis_tid(a_m_tid), .m_axis_tdest(a_m_tdest),
    .busy(a_busy), .pkt_count(a_pkt), .drop_count(a_drop)
  );

  axis_grant_gate #(
    .IF_COUNT(1), .AXIS_DATA_WIDTH(DW), .AXIS_KEEP_WIDTH(KW), .AXIS_ID_WIDTH(IW),
    .AXIS_DEST_WIDTH(SW), .AXIS_USER_WIDTH(UW), .COUNT_WIDTH(2), .DROP_WHEN_IDLE(1)
  ) dut_b (
    .clk(clk), .rst(rst), .grant(b_grant),
    .s_axis_tdata(b_s_tdata), .s_axis_tkeep(b_s_tkeep), .s_axis_tvalid(b_s_tvalid),
    .s_axis_tready(b_s_tready), .s_axis_tlast(b_s_tlast), .s_axis_tuser(b_s_tuser),
    .s_axis_tid(b_s_tid), .s_axis_tdest(b_s_tdest),
    .m_axis_tdata(b_m_tdata), .m_axis_tkeep(b_m_tkeep), .m_axis_tvalid(b_m_tvalid),
    .m_axis_tready(b_m_tready), .m_axis_tlast(b_m_tlast), .m_axis_tuser(b_m_tuser),
    .m_axis_tid(b_m_tid), .m_axis_tdest(b_m_tdest),
    .busy(b_busy), .pkt_count(b_pkt), .drop_count(b_drop)
  );

  task automatic set_a(input int ch, input logic v, input logic [15:0] d, input logic l);
    a_s_tvalid[ch]          = v;
    a_s_tdata[ch*DW +: DW]  = d;
    a_s_tkeep[ch*KW +: KW]  = 2'b11;
    a_s_tlast[ch]           = l;
    a_s_tuser[ch*UW +: UW]  = d[7:0] ^ 8'h5A;
    a_s_tid[ch*IW +: IW]    = 1'b0;
    a_s_tdest[ch*SW +: SW]  = 9'h1A5;
  endtask

  task automatic set_b(input logic v, input logic [15:0] d, input logic l);
    b_s_tvalid = v;
    b_s_tdata  = d;
    b_s_tkeep  = 2'b11;
    b_s_tlast  = l;
    b_s_tuser  = d[7:0] ^ 8'h5A;
    b_s_tid    = 1'b0;
    b_s_tdest  = 9'h0C3;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    a_grant = 2'b11; a_m_tready = 2'b11;
    set_a(0, 1'b1, 16'hAAAA, 1'b0);
    set_a(1, 1'b1, 16'hBBBB, 1'b0);
    b_grant = 1'b0; b_m_tready = 1'b1;
    set_b(1'b1, 16'hCCCC, 1'b0);
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({a_m_tvalid, a_s_tready, a_busy, b_m_tvalid, b_s_tready, b_busy} !== 9'd0) begin
        errors++;
        $display("FAIL reset_ctrl: got %b expected all zero",
                 {a_m_tvalid, a_s_tready, a_busy, b_m_tvalid, b_s_tready, b_busy});
      end
      checks++;
      if ({a_pkt, a_drop, b_pkt, b_drop} !== 36'd0) begin
        errors++;
        $display("FAIL reset_counters: got %h expected 0", {a_pkt, a_drop, b_pkt, b_drop});
      end
      checks++;
      if ({a_m_tdata, a_m_tlast, a_m_tuser, a_m_tdest, b_m_tdata} !== '0) begin
        errors++;
        $display("FAIL reset_payload: got %h expected 0", {a_m_tdata, a_m_tuser, b_m_tdata});
      end
    end
    rst = 1'b0;
    a_grant = 2'b00;
    set_a(0, 1'b0, 16'h0, 1'b0);
    set_a(1, 1'b0, 16'h0, 1'b0);
    set_b(1'b0, 16'h0, 1'b0);
    @(negedge clk);
    checks++;
    if ({a_busy, a_m_tvalid, b_busy} !== 5'd0) begin
      errors++;
      $display("FAIL reset_release_idle: got %b expected 0", {a_busy, a_m_tvalid, b_busy});
    end
  endtask

  task automatic test_pass_basic;
    int idx = 0;
    int rx = 0;
    int last_cyc = -1;
    logic acc;
    logic [15:0] exp_d;
    a_grant[0] = 1'b1;
    a_m_tready = 2'b11;
    set_a(0, 1'b1, 16'h2100, 1'b0);
    acc = a_s_tvalid[0] & a_s_tready[0];
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      if (a_m_tvalid[0]) begin
        exp_d = 16'h2100 + 16'(rx);
        checks++;
        if (rx >= 4) begin
          errors++;
          $display("FAIL basic_extra_beat: got %h expected no beat", a_m_tdata[15:0]);
        end else begin
          if (a_m_tdata[15:0] !== exp_d) begin
            errors++;
            $display("FAIL basic_data: got %h expected %h", a_m_tdata[15:0], exp_d);
          end
          checks++;
          if (a_m_tlast[0] !== (rx == 3)) begin
            errors++;
            $display("FAIL basic_tlast: got %b expected %b", a_m_tlast[0], (rx == 3));
          end
          checks++;
          if ({a_m_tuser[7:0], a_m_tdest[8:0], a_m_tkeep[1:0]} !== {exp_d[7:0] ^ 8'h5A, 9'h1A5, 2'b11}) begin
            errors++;
            $display("FAIL basic_sideband: got %h/%h/%b expected %h/1a5/11",
                     a_m_tuser[7:0], a_m_tdest[8:0], a_m_tkeep[1:0], exp_d[7:0] ^ 8'h5A);
          end
          if (rx > 0) begin
            checks++;
            if (cyc != last_cyc + 1) begin
              errors++;
              $display("FAIL basic_throughput: got gap %0d expected 1", cyc - last_cyc);
            end
          end
        end
        rx++;
        last_cyc = cyc;
      end
      if (acc) idx++;
      if (idx < 4) set_a(0, 1'b1, 16'h2100 + 16'(idx), idx == 3);
      else         set_a(0, 1'b0, 16'h0, 1'b0);
      acc = a_s_tvalid[0] & a_s_tready[0];
    end
    a_grant[0] = 1'b0;
    checks++;
    if (rx != 4) begin
      errors++;
      $display("FAIL basic_beat_count: got %0d expected 4", rx);
    end
    checks++;
    if (a_pkt[7:0] !== 8'd1 || a_busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL basic_pkt_count: got %0d busy %b expected 1 busy 0", a_pkt[7:0], a_busy[0]);
    end
  endtask

  task automatic test_grant_drop;
    int idx = 0;
    int rx = 0;
    logic acc;
    logic prev_stall = 1'b0;
    logic [15:0] prev_d = 16'h0;
    logic [15:0] exp_d;
    a_grant[0] = 1'b1;
    set_a(0, 1'b1, 16'h3100, 1'b0);
    acc = a_s_tvalid[0] & a_s_tready[0];
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      a_m_tready[0] = cyc[0];
      if (a_m_tvalid[0]) begin
        exp_d = 16'h3100 + 16'(rx);
        checks++;
        if (rx >= 6) begin
          errors++;
          $display("FAIL grantdrop_extra_beat: got %h expected no beat", a_m_tdata[15:0]);
        end else if (a_m_tdata[15:0] !== exp_d || a_m_tlast[0] !== (rx == 5)) begin
          errors++;
          $display("FAIL grantdrop_data: got %h last %b expected %h last %b",
                   a_m_tdata[15:0], a_m_tlast[0], exp_d, (rx == 5));
        end
        if (prev_stall) begin
          checks++;
          if (a_m_tdata[15:0] !== prev_d) begin
            errors++;
            $display("FAIL grantdrop_stall_stable: got %h expected %h", a_m_tdata[15:0], prev_d);
          end
        end
        if (a_m_tready[0]) rx++;
      end
      prev_stall = a_m_tvalid[0] & ~a_m_tready[0];
      prev_d     = a_m_tdata[15:0];
      if (acc) begin
        idx++;
        if (idx == 1) a_grant[0] = 1'b0;
      end
      if (idx < 6) set_a(0, 1'b1, 16'h3100 + 16'(idx), idx == 5);
      else         set_a(0, 1'b0, 16'h0, 1'b0);
      acc = a_s_tvalid[0] & a_s_tready[0];
    end
    checks++;
    if (rx != 6) begin
      errors++;
      $display("FAIL grantdrop_beat_count: got %0d expected 6", rx);
    end
    checks++;
    if (a_pkt[7:0] !== 8'd2) begin
      errors++;
      $display("FAIL grantdrop_pkt_count: got %0d expected 2", a_pkt[7:0]);
    end
    // Next packet waits in IDLE while ungranted
    a_m_tready[0] = 1'b1;
    set_a(0, 1'b1, 16'h3A00, 1'b1);
    repeat (4) begin
      @(negedge clk);
      checks++;
      if ({a_busy[0], a_s_tready[0], a_m_tvalid[0]} !== 3'b000) begin
        errors++;
        $display("FAIL grantdrop_held_idle: got busy/rdy/vld %b expected 000",
                 {a_busy[0], a_s_tready[0], a_m_tvalid[0]});
      end
    end
    a_grant[0] = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_busy[0], a_s_tready[0]} !== 2'b11) begin
      errors++;
      $display("FAIL grantdrop_enter_pass: got busy/rdy %b expected 11", {a_busy[0], a_s_tready[0]});
    end
    @(negedge clk);
    set_a(0, 1'b0, 16'h0, 1'b0);
    a_grant[0] = 1'b0;
    checks++;
    if ({a_m_tvalid[0], a_m_tlast[0], a_m_tdata[15:0], a_busy[0], a_pkt[7:0]} !== {2'b11, 16'h3A00, 1'b0, 8'd3}) begin
      errors++;
      $display("FAIL grantdrop_single_beat: got vld %b data %h busy %b pkt %0d expected 1 3a00 0 3",
               a_m_tvalid[0], a_m_tdata[15:0], a_busy[0], a_pkt[7:0]);
    end
  endtask

  task automatic test_back_to_back;
    int idx = 0;
    int rx = 0;
    int n_acc = 0;
    int acc_cyc[2];
    logic acc;
    a_grant[0] = 1'b1;
    a_m_tready = 2'b11;
    acc_cyc[0] = -10;
    acc_cyc[1] = -10;
    set_a(0, 1'b1, 16'h4100, 1'b1);
    acc = a_s_tvalid[0] & a_s_tready[0];
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (a_m_tvalid[0]) begin
        checks++;
        if (rx >= 2 || a_m_tdata[15:0] !== 16'h4100 + 16'(rx) || a_m_tlast[0] !== 1'b1) begin
          errors++;
          $display("FAIL b2b_data: got %h last %b expected %h last 1 (beat %0d)",
                   a_m_tdata[15:0], a_m_tlast[0], 16'h4100 + 16'(rx), rx);
        end
        rx++;
      end
      if (acc) idx++;
      if (idx < 2) set_a(0, 1'b1, 16'h4100 + 16'(idx), 1'b1);
      else         set_a(0, 1'b0, 16'h0, 1'b0);
      acc = a_s_tvalid[0] & a_s_tready[0];
      if (acc && n_acc < 2) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
      end
    end
    a_grant[0] = 1'b0;
    checks++;
    if (acc_cyc[1] - acc_cyc[0] != 2) begin
      errors++;
      $display("FAIL b2b_idle_gap: got %0d expected 2", acc_cyc[1] - acc_cyc[0]);
    end
    checks++;
    if (rx != 2 || a_pkt[7:0] !== 8'd5) begin
      errors++;
      $display("FAIL b2b_count: got beats %0d pkt %0d expected 2 and 5", rx, a_pkt[7:0]);
    end
  endtask

  task automatic test_drop_mode;
    int idx;
    int n_acc;
    logic acc;
    b_grant = 1'b0;
    b_m_tready = 1'b1;
    for (int phase = 0; phase < 2; phase++) begin
      idx = 0;
      n_acc = 0;
      set_b(1'b1, 16'h5000, 1'b0);
      acc = b_s_tvalid & b_s_tready;
      for (int cyc = 0; cyc < 16; cyc++) begin
        @(negedge clk);
        checks++;
        if (b_m_tvalid !== 1'b0) begin
          errors++;
          $display("FAIL drop_m_tvalid: got %b expected 0", b_m_tvalid);
        end
        if (acc) begin
          idx++;
          n_acc++;
        end
        if (idx < 6) set_b(1'b1, 16'h5000 + 16'(idx), (idx % 3) == 2);
        else         set_b(1'b0, 16'h0, 1'b0);
        acc = b_s_tvalid & b_s_tready;
      end
      checks++;
      if (n_acc != 6) begin
        errors++;
        $display("FAIL drop_beats_consumed: got %0d expected 6", n_acc);
      end
      checks++;
      if ({b_drop, b_pkt, b_busy} !== {(phase == 0) ? 2'd2 : 2'd0, 2'd0, 1'b0}) begin
        errors++;
        $display("FAIL drop_counters: got drop %0d pkt %0d busy %b expected drop %0d pkt 0 busy 0",
                 b_drop, b_pkt, b_busy, (phase == 0) ? 2 : 0);
      end
    end
  endtask

  task automatic test_two_channel;
    int idx = 0;
    int n_acc = 0;
    logic acc;
    a_grant = 2'b01;
    a_m_tready = 2'b10;
    set_a(0, 1'b1, 16'h6100, 1'b0);
    set_a(1, 1'b1, 16'h6200, 1'b1);
    acc = a_s_tvalid[0] & a_s_tready[0];
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      checks++;
      if ({a_busy[1], a_s_tready[1], a_m_tvalid[1]} !== 3'b000) begin
        errors++;
        $display("FAIL twoch_ch1_idle: got busy/rdy/vld %b expected 000",
                 {a_busy[1], a_s_tready[1], a_m_tvalid[1]});
      end
      if (acc) begin
        idx++;
        n_acc++;
      end
      set_a(0, 1'b1, 16'h6100 + 16'(idx), idx == 3);
      acc = a_s_tvalid[0] & a_s_tready[0];
    end
    checks++;
    if (n_acc != 2) begin
      errors++;
      $display("FAIL twoch_ch0_accepted: got %0d expected 2", n_acc);
    end
    checks++;
    if ({a_s_tready[0], a_m_tvalid[0], a_busy[0], a_m_tdata[15:0]} !== {3'b011, 16'h6100}) begin
      errors++;
      $display("FAIL twoch_ch0_stall: got rdy %b vld %b busy %b data %h expected 0 1 1 6100",
               a_s_tready[0], a_m_tvalid[0], a_busy[0], a_m_tdata[15:0]);
    end
    a_grant[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    set_a(1, 1'b0, 16'h0, 1'b0);
    a_grant[1] = 1'b0;
    checks++;
    if ({a_m_tvalid[1], a_m_tlast[1], a_m_tdata[31:16], a_pkt[15:8]} !== {2'b11, 16'h6200, 8'd1}) begin
      errors++;
      $display("FAIL twoch_ch1_pass: got vld %b data %h pkt %0d expected 1 6200 1",
               a_m_tvalid[1], a_m_tdata[31:16], a_pkt[15:8]);
    end
    checks++;
    if ({a_s_tready[0], a_m_tvalid[0], a_m_tdata[15:0], a_pkt[7:0]} !== {2'b01, 16'h6100, 8'd5}) begin
      errors++;
      $display("FAIL twoch_ch0_unaffected: got rdy %b vld %b data %h pkt %0d expected 0 1 6100 5",
               a_s_tready[0], a_m_tvalid[0], a_m_tdata[15:0], a_pkt[7:0]);
    end
  endtask

  task automatic test_reset_mid;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_m_tvalid, a_busy, a_s_tready} !== 6'd0) begin
      errors++;
      $display("FAIL midrst_ctrl: got vld %b busy %b rdy %b expected 0",
               a_m_tvalid, a_busy, a_s_tready);
    end
    checks++;
    if ({a_pkt, a_drop, a_m_tdata} !== '0) begin
      errors++;
      $display("FAIL midrst_counters: got pkt %h drop %h data %h expected 0", a_pkt, a_drop, a_m_tdata);
    end
    rst = 1'b0;
    a_grant = 2'b00;
    a_m_tready = 2'b11;
    set_a(0, 1'b0, 16'h0, 1'b0);
    set_a(1, 1'b0, 16'h0, 1'b0);
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({a_m_tvalid, a_busy} !== 4'd0) begin
        errors++;
        $display("FAIL midrst_no_leftover: got vld %b busy %b expected 0", a_m_tvalid, a_busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pass_basic();
    test_grant_drop();
    test_back_to_back();
    test_drop_mode();
    test_two_channel();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
